// File: rtl/histo_stream_accum.sv
// Frame histogram engine: bins qualifying pixels into a RAM through a forwarding
// read-modify-write pipeline, then streams every bin out with clear-on-read.
module histo_stream_accum #(
    parameter int PIXEL_W  = 10,
    parameter int BIN_BITS = 10,
    parameter int COUNT_W  = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PIXEL_W-1:0]  pixel_data,
    input  logic                frame_valid,
    input  logic                line_valid,
    output logic [COUNT_W-1:0]  out_data,
    output logic [BIN_BITS-1:0] out_bin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                busy,
    output logic [7:0]          dropped_frames,
    output logic [15:0]         frame_id
);

    localparam int NBINS = 1 << BIN_BITS;
    localparam logic [BIN_BITS-1:0] LAST_BIN = {BIN_BITS{1'b1}};
    localparam logic [BIN_BITS-1:0] BIN_ONE  = BIN_BITS'(32'd1);
    localparam logic [BIN_BITS:0]   RD_ONE   = (BIN_BITS+1)'(32'd1);
    localparam logic [COUNT_W-1:0]  CNT_MAX  = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0]  CNT_ONE  = COUNT_W'(32'd1);

    typedef enum logic [2:0] {
        S_CLEAR   = 3'd0,
        S_ARMED   = 3'd1,
        S_ACCUM   = 3'd2,
        S_DRAIN   = 3'd3,
        S_READOUT = 3'd4
    } state_t;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    state_t              r_state;
    logic                r_fv_prev;
    logic [BIN_BITS-1:0] r_clr_addr;
    logic [1:0]          r_drain_cnt;
    logic [BIN_BITS:0]   r_rd_cnt;
    logic [BIN_BITS-1:0] r_pf_bin;
    logic                r_pf_valid;
    logic                r_s1_valid, r_s2_valid, r_s3_valid;
    logic [BIN_BITS-1:0] r_s1_bin, r_s2_bin, r_s3_bin;
    logic [COUNT_W-1:0]  r_s3_data;
    logic [COUNT_W-1:0]  r_rd_data;
    logic [COUNT_W-1:0]  r_mem [0:NBINS-1];

    logic                w_fv_rise, w_fv_fall, w_pix_ok;
    logic                w_accept, w_load, w_issue;
    logic [COUNT_W-1:0]  w_old, w_inc;
    logic                w_we, w_re;
    logic [BIN_BITS-1:0] w_wa, w_ra;
    logic [COUNT_W-1:0]  w_wd;

    assign w_fv_rise = frame_valid && !r_fv_prev;
    assign w_fv_fall = !frame_valid && r_fv_prev;
    assign w_pix_ok  = frame_valid && line_valid &&
                       ((r_state == S_ACCUM) || ((r_state == S_ARMED) && w_fv_rise));
    assign w_accept  = out_valid && out_ready;
    assign w_load    = r_pf_valid && (!out_valid || out_ready);
    // The prefetch slot only refills when it is empty or drains this cycle.
    assign w_issue   = (r_state == S_READOUT) && !r_rd_cnt[BIN_BITS] && (!r_pf_valid || w_load);
    // The read that raced the previous write missed it, so take the written value.
    assign w_old     = (r_s3_valid && (r_s3_bin == r_s2_bin)) ? r_s3_data : r_rd_data;
    assign w_inc     = sat_inc(w_old);

    // RAM port selection: clearing, clear-on-read, or the accumulate write stage.
    always_comb begin
        w_we = 1'b0;
        w_wa = '0;
        w_wd = '0;
        w_ra = r_s1_bin;
        w_re = 1'b1;
        case (r_state)
            S_CLEAR: begin
                w_we = 1'b1;
                w_wa = r_clr_addr;
            end
            S_READOUT: begin
                w_we = w_accept;
                w_wa = out_bin;
                w_ra = r_rd_cnt[BIN_BITS-1:0];
                w_re = w_issue;
            end
            default: begin
                w_we = r_s2_valid;
                w_wa = r_s2_bin;
                w_wd = w_inc;
            end
        endcase
        w_we = w_we && !reset;
    end

    // Bin storage with synchronous read.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_wa] <= w_wd;
        end
        if (w_re) begin
            r_rd_data <= r_mem[w_ra];
        end
    end

    // Accumulate pipeline: index register, RAM read, add/write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
            r_s1_bin   <= '0;
            r_s2_bin   <= '0;
            r_s3_bin   <= '0;
            r_s3_data  <= '0;
        end else begin
            r_s1_valid <= w_pix_ok;
            r_s1_bin   <= pixel_data[PIXEL_W-1 -: BIN_BITS];
            r_s2_valid <= r_s1_valid;
            r_s2_bin   <= r_s1_bin;
            r_s3_valid <= r_s2_valid;
            r_s3_bin   <= r_s2_bin;
            r_s3_data  <= w_inc;
        end
    end

    // Control FSM with registered stream outputs and frame accounting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_CLEAR;
            r_fv_prev      <= 1'b0;
            r_clr_addr     <= '0;
            r_drain_cnt    <= 2'd0;
            r_rd_cnt       <= '0;
            r_pf_bin       <= '0;
            r_pf_valid     <= 1'b0;
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
            out_data       <= '0;
            out_bin        <= '0;
            busy           <= 1'b1;
            dropped_frames <= 8'd0;
            frame_id       <= 16'd0;
        end else begin
            r_fv_prev <= frame_valid;
            if (w_fv_rise && (r_state != S_ARMED) && (r_state != S_ACCUM) &&
                (dropped_frames != 8'hFF)) begin
                dropped_frames <= dropped_frames + 8'd1;
            end
            case (r_state)
                S_CLEAR: begin
                    r_clr_addr <= r_clr_addr + BIN_ONE;
                    if (r_clr_addr == LAST_BIN) begin
                        r_state <= S_ARMED;
                        busy    <= 1'b0;
                    end
                end
                S_ARMED: begin
                    if (w_fv_rise) begin
                        r_state <= S_ACCUM;
                        busy    <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (w_fv_fall) begin
                        r_state     <= S_DRAIN;
                        r_drain_cnt <= 2'd0;
                    end
                end
                S_DRAIN: begin
                    r_drain_cnt <= r_drain_cnt + 2'd1;
                    if (r_drain_cnt == 2'd2) begin
                        r_state    <= S_READOUT;
                        r_rd_cnt   <= '0;
                        r_pf_valid <= 1'b0;
                    end
                end
                S_READOUT: begin
                    if (w_issue) begin
                        r_rd_cnt <= r_rd_cnt + RD_ONE;
                        r_pf_bin <= r_rd_cnt[BIN_BITS-1:0];
                    end
                    r_pf_valid <= w_issue || (r_pf_valid && !w_load);
                    if (w_load) begin
                        out_valid <= 1'b1;
                        out_data  <= r_rd_data;
                        out_bin   <= r_pf_bin;
                        out_last  <= (r_pf_bin == LAST_BIN);
                    end else if (w_accept) begin
                        out_valid <= 1'b0;
                    end
                    if (w_accept && out_last) begin
                        r_state  <= S_ARMED;
                        busy     <= 1'b0;
                        out_last <= 1'b0;
                        frame_id <= frame_id + 16'd1;
                    end
                end
                default: begin
                    r_state    <= S_CLEAR;
                    busy       <= 1'b1;
                    r_clr_addr <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_histo_stream_accum.sv
// Directed-sequence bench with randomized frames and back-pressure; a 24-bit and a
// 4-bit-counter instance run in lockstep against a per-frame histogram model.
module tb_histo_stream_accum;

    logic        clk = 1'b0;
    logic        reset, frame_valid, line_valid, out_ready;
    logic [9:0]  pixel_data;
    logic [23:0] out_data;
    logic [9:0]  out_bin;
    logic        out_valid, out_last, busy;
    logic [7:0]  dropped_frames;
    logic [15:0] frame_id;
    logic [3:0]  o4_data;
    logic [9:0]  o4_bin;
    logic        o4_valid, o4_last, o4_busy;
    logic [7:0]  o4_dropped;
    logic [15:0] o4_fid;

    int         n_vec = 0;
    int         n_err = 0;
    int         hist[1024];
    logic [9:0] pq[$];
    int         exp_fid = 0;
    int         exp_drop = 0;

    always #5 clk = ~clk;

    histo_stream_accum dut (
        .clk(clk), .reset(reset), .pixel_data(pixel_data), .frame_valid(frame_valid),
        .line_valid(line_valid), .out_data(out_data), .out_bin(out_bin),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy),
        .dropped_frames(dropped_frames), .frame_id(frame_id)
    );

    histo_stream_accum #(.PIXEL_W(10), .BIN_BITS(10), .COUNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .pixel_data(pixel_data), .frame_valid(frame_valid),
        .line_valid(line_valid), .out_data(o4_data), .out_bin(o4_bin),
        .out_valid(o4_valid), .out_ready(out_ready), .out_last(o4_last), .busy(o4_busy),
        .dropped_frames(o4_dropped), .frame_id(o4_fid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One reset edge, reset-value checks, then measure how long the clear sweep keeps busy high.
    task automatic apply_reset();
        int cnt;
        @(negedge clk);
        reset = 1'b1; frame_valid = 1'b0; line_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_bin", 32'(out_bin), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_dropped", 32'(dropped_frames), 32'd0);
        check("rst_frame_id", 32'(frame_id), 32'd0);
        check("rst4_out_valid", 32'(o4_valid), 32'd0);
        reset = 1'b0;
        cnt = 0;
        while (busy && cnt < 3000) begin
            cnt++;
            @(negedge clk);
        end
        check("clear_cycles", 32'(cnt), 32'd1024);
        exp_fid = 0;
        exp_drop = 0;
    endtask

    // Play pq as one frame; optional line_valid gaps and line_valid-only lead-in are not counted.
    task automatic send_frame(input int gaps);
        foreach (hist[i]) hist[i] = 0;
        check("armed_before_frame", 32'(busy), 32'd0);
        if (gaps != 0) begin
            repeat (3) begin
                @(negedge clk);
                frame_valid = 1'b0; line_valid = 1'b1; pixel_data = 10'($urandom);
            end
        end
        foreach (pq[i]) begin
            if (gaps != 0 && $urandom_range(0, 3) == 0) begin
                @(negedge clk);
                frame_valid = 1'b1; line_valid = 1'b0; pixel_data = 10'($urandom);
            end
            @(negedge clk);
            frame_valid = 1'b1; line_valid = 1'b1; pixel_data = pq[i];
            hist[pq[i]]++;
        end
        @(negedge clk);
        frame_valid = 1'b0; line_valid = 1'b0;
    endtask

    // Consume stop_at beats; mode 1 randomizes out_ready; drop_at >= 0 pulses a new frame mid-stream.
    task automatic readout(input int mode, input int stop_at, input int drop_at);
        int k = 0, idx = 0, first = -1, last_k = 0, drop_ph = 0, e4;
        logic        stall_p = 1'b0;
        logic [23:0] sv_data = '0;
        logic [9:0]  sv_bin = '0;
        logic        sv_last = 1'b0;
        out_ready = (mode == 0);
        while (idx < stop_at && k < 20000) begin
            @(negedge clk);
            k++;
            if (drop_at >= 0 && idx >= drop_at && drop_ph < 4) begin
                drop_ph++;
                frame_valid = (drop_ph <= 3);
                line_valid = 1'b1;
                pixel_data = 10'($urandom);
            end
            if (first < 0 && out_valid) begin
                first = k;
                check("first_valid_latency", 32'(k), 32'd6);
            end
            if (stall_p) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(sv_data));
                check("stall_bin", 32'(out_bin), 32'(sv_bin));
                check("stall_last", 32'(out_last), 32'(sv_last));
            end
            check("lockstep_valid", 32'(o4_valid), 32'(out_valid));
            if (mode != 0) out_ready = ($urandom_range(0, 1) == 1);
            if (out_valid && out_ready) begin
                e4 = (hist[idx] > 15) ? 15 : hist[idx];
                check("beat_bin", 32'(out_bin), 32'(idx));
                check("beat_data", 32'(out_data), 32'(hist[idx]));
                check("beat_last", 32'(out_last), 32'(idx == 1023));
                check("beat4_bin", 32'(o4_bin), 32'(idx));
                check("beat4_data_sat", 32'(o4_data), 32'(e4));
                idx++;
                last_k = k;
            end
            stall_p = out_valid && !out_ready;
            sv_data = out_data; sv_bin = out_bin; sv_last = out_last;
        end
        check("beats_delivered", 32'(idx), 32'(stop_at));
        if (stop_at == 1024) begin
            if (mode == 0) check("no_bubbles", 32'(last_k - first + 1), 32'd1024);
            exp_fid++;
            if (drop_at >= 0) exp_drop++;
            @(negedge clk);
            check("end_frame_id", 32'(frame_id), 32'(exp_fid));
            check("end4_frame_id", 32'(o4_fid), 32'(exp_fid));
            check("end_out_valid", 32'(out_valid), 32'd0);
            check("end_busy", 32'(busy), 32'd0);
            check("end_dropped", 32'(dropped_frames), 32'(exp_drop));
            out_ready = 1'b0;
        end
    endtask

    task automatic make_random(input int n);
        pq.delete();
        repeat (n) begin
            if ($urandom_range(0, 1) == 1) pq.push_back(10'($urandom_range(0, 15)));
            else pq.push_back(10'($urandom));
        end
    endtask

    initial begin
        reset = 1'b1; frame_valid = 1'b0; line_valid = 1'b0; out_ready = 1'b0;
        pixel_data = 10'd0;
        apply_reset();

        // Sixteen full-scale pixels land in the last bin.
        pq.delete();
        repeat (16) pq.push_back(10'h3FF);
        send_frame(0);
        readout(0, 1024, -1);

        // Back-to-back repeats exercise the write-to-read forwarding.
        pq = '{10'd5, 10'd5, 10'd5, 10'd6, 10'd5};
        send_frame(0);
        readout(0, 1024, -1);

        // Twenty hits on one bin saturate the 4-bit instance.
        pq.delete();
        repeat (20) pq.push_back(10'd7);
        send_frame(0);
        readout(1, 1024, -1);

        // Same random frame twice under back-pressure: counts must not carry over.
        make_random(400);
        send_frame(0);
        readout(1, 1024, -1);
        send_frame(0);
        readout(1, 1024, -1);
        make_random(300);
        send_frame(1);
        readout(1, 1024, -1);

        // A frame starting mid-readout is dropped; the following frame is captured.
        make_random(200);
        send_frame(0);
        readout(1, 1024, 100);
        make_random(250);
        send_frame(1);
        readout(0, 1024, -1);

        // Reset part-way through a readout, then a clean frame.
        make_random(200);
        send_frame(0);
        readout(1, 300, -1);
        apply_reset();
        make_random(150);
        send_frame(1);
        readout(0, 1024, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
